// File: rtl/inst_fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch unit.
// Holds FSM encoding, next-pc select encoding, mcause codes and the output bundle.
// No logic here beyond a pc alignment helper.
package inst_fetch_unit_pkg;

    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,   // request outstanding (or about to be issued)
        ST_HOLD = 2'd1,   // IF outputs valid, waiting for consumption
        ST_DROP = 2'd2    // old request still in flight, its response is discarded
    } fetch_state_e;

    typedef enum logic [1:0] {
        PC_HOLD     = 2'd0,
        PC_REDIRECT = 2'd1,
        PC_PREDICT  = 2'd2
    } pc_sel_e;

    localparam logic [63:0] RESET_PC_DEFAULT    = 64'h0;
    localparam logic [63:0] INST_BYTES          = 64'd4;
    localparam logic [3:0]  MCAUSE_MISALIGNED   = 4'd0;
    localparam logic [3:0]  MCAUSE_ACCESS_FAULT = 4'd1;

    // Registered IF/ID payload.
    typedef struct packed {
        logic [63:0] pc;
        logic [63:0] npc;
        logic [63:0] predict_pc;
        logic [31:0] inst;
        logic        except_happen;
        logic [3:0]  except_cause;
    } if_out_t;

    // Instructions are 4-byte aligned; anything else is a misaligned fetch.
    function automatic logic pc_aligned(input logic [63:0] pc);
        return (pc & 64'h3) == 64'h0;
    endfunction

endpackage

// File: rtl/inst_fetch_unit_if.sv
// Instruction-memory request/response bundle between fetch unit and memory.
// Request is level-held until the single-cycle ack strobe.
// No backpressure beyond the req/ack handshake itself.
interface inst_fetch_unit_if;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        imem_fault;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata,
        input  imem_fault
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata,
        output imem_fault
    );
endinterface

// File: rtl/inst_fetch_unit_pc_sel.sv
// Next-pc selection: keep current pc, take a redirect, or follow the prediction.
// Purely combinational, zero latency.
// No flow control; the caller decides which source applies this cycle.
module fetch_pc_sel
    import inst_fetch_unit_pkg::*;
(
    input  pc_sel_e     sel,
    input  logic [63:0] pc_q,
    input  logic [63:0] redirect_pc,
    input  logic [63:0] predict_pc,
    output logic [63:0] pc_d
);

    // Mux the three candidate next-pc sources.
    always_comb begin
        pc_d = pc_q;
        unique case (sel)
            PC_REDIRECT: pc_d = redirect_pc;
            PC_PREDICT:  pc_d = predict_pc;
            default:     pc_d = pc_q;
        endcase
    end

endmodule

// File: rtl/inst_fetch_unit.sv
// Single-outstanding instruction fetch: one imem request per instruction, result held for IF/ID.
// Latency: outputs valid the cycle after imem_ack; at most one instruction every two cycles.
// Backpressure: stall holds the HOLD state and all outputs; flush redirects and drops in-flight data.
module inst_fetch_unit
    import inst_fetch_unit_pkg::*;
#(
    parameter logic [63:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      stall,
    input  logic                      flush,
    input  logic [63:0]               redirect_pc,
    input  logic                      bp_taken,
    input  logic [63:0]               bp_target,
    inst_fetch_unit_if.master         imem,
    output logic [63:0]               pc_if,
    output logic [63:0]               npc_if,
    output logic [63:0]               predict_pc_if,
    output logic [31:0]               inst_if,
    output logic                      valid_if,
    output logic                      except_happen_if,
    output logic [3:0]                except_cause_if
);

    fetch_state_e state_q, state_d;
    logic [63:0]  pc_q, pc_d;
    logic         req_q, req_d;
    logic [63:0]  addr_q, addr_d;
    if_out_t      out_q, out_d;
    pc_sel_e      pc_sel;
    logic [63:0]  pc_plus4;

    assign pc_plus4 = pc_q + INST_BYTES;

    fetch_pc_sel u_pc_sel (
        .sel         (pc_sel),
        .pc_q        (pc_q),
        .redirect_pc (redirect_pc),
        .predict_pc  (out_q.predict_pc),
        .pc_d        (pc_d)
    );

    // FSM next state, output payload capture and next-pc source choice.
    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        pc_sel  = PC_HOLD;
        unique case (state_q)
            ST_REQ: begin
                if (flush) begin
                    // A request with no ack yet must still be drained; a
                    // same-cycle ack is simply ignored.
                    pc_sel  = PC_REDIRECT;
                    state_d = (req_q && !imem.imem_ack) ? ST_DROP : ST_REQ;
                end else if (!pc_aligned(pc_q)) begin
                    state_d                  = ST_HOLD;
                    out_d.pc                 = pc_q;
                    out_d.npc                = pc_plus4;
                    out_d.predict_pc         = pc_plus4;
                    out_d.inst               = 32'h0;
                    out_d.except_happen      = 1'b1;
                    out_d.except_cause       = MCAUSE_MISALIGNED;
                end else if (req_q && imem.imem_ack) begin
                    state_d                  = ST_HOLD;
                    out_d.pc                 = pc_q;
                    out_d.npc                = pc_plus4;
                    out_d.predict_pc         = bp_taken ? bp_target : pc_plus4;
                    out_d.inst               = imem.imem_fault ? 32'h0 : imem.imem_rdata;
                    out_d.except_happen      = imem.imem_fault;
                    out_d.except_cause       = imem.imem_fault ? MCAUSE_ACCESS_FAULT
                                                               : MCAUSE_MISALIGNED;
                end
            end
            ST_HOLD: begin
                if (flush) begin
                    pc_sel  = PC_REDIRECT;
                    state_d = ST_REQ;
                end else if (!stall) begin
                    pc_sel  = PC_PREDICT;
                    state_d = ST_REQ;
                end
            end
            ST_DROP: begin
                // Later flushes only retarget the pc; the stale ack ends DROP.
                if (flush) begin
                    pc_sel = PC_REDIRECT;
                end
                if (imem.imem_ack) begin
                    state_d = ST_REQ;
                end
            end
            default: begin
                state_d = ST_REQ;
            end
        endcase
    end

    // Registered request: old address is kept while draining, otherwise it tracks the pc.
    always_comb begin
        req_d  = (state_d == ST_DROP) || ((state_d == ST_REQ) && pc_aligned(pc_d));
        addr_d = (state_d == ST_DROP) ? addr_q : pc_d;
    end

    // State, pc, request and IF payload registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_REQ;
            pc_q    <= RESET_PC;
            req_q   <= 1'b0;
            addr_q  <= RESET_PC;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            req_q   <= req_d;
            addr_q  <= addr_d;
            out_q   <= out_d;
        end
    end

    assign imem.imem_req    = req_q;
    assign imem.imem_addr   = addr_q;
    assign pc_if            = out_q.pc;
    assign npc_if           = out_q.npc;
    assign predict_pc_if    = out_q.predict_pc;
    assign inst_if          = out_q.inst;
    assign except_happen_if = out_q.except_happen;
    assign except_cause_if  = out_q.except_cause;
    assign valid_if         = (state_q == ST_HOLD);

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed bench for inst_fetch_unit: cycle table of inputs and hand-computed outputs,
// followed by reset-release and mid-request reset sequences.
// Outputs are sampled 1 time unit after each rising edge; inputs change on falling edges.
module tb_inst_fetch_unit;

    typedef struct {
        logic        stall;
        logic        flush;
        logic [63:0] redirect_pc;
        logic        bp_taken;
        logic [63:0] bp_target;
        logic        ack;
        logic [31:0] rdata;
        logic        fault;
    } in_t;

    typedef struct {
        logic        req;
        logic [63:0] addr;
        logic        valid;
        logic [63:0] pc;
        logic [63:0] npc;
        logic [63:0] pred;
        logic [31:0] inst;
        logic        exc;
        logic [3:0]  cause;
    } ex_t;

    localparam int NV = 26;
    localparam logic [63:0] TOP = 64'hFFFF_FFFF_FFFF_FFFC;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic [63:0] redirect_pc = '0;
    logic        bp_taken = 1'b0;
    logic [63:0] bp_target = '0;
    logic [63:0] pc_if, npc_if, predict_pc_if;
    logic [31:0] inst_if;
    logic        valid_if, except_happen_if;
    logic [3:0]  except_cause_if;

    int checks = 0;
    int errors = 0;

    in_t vin[NV];
    ex_t vex[NV];

    inst_fetch_unit_if imem_bus ();

    inst_fetch_unit #(.RESET_PC(64'h0)) dut (
        .clk              (clk),
        .rst              (rst),
        .stall            (stall),
        .flush            (flush),
        .redirect_pc      (redirect_pc),
        .bp_taken         (bp_taken),
        .bp_target        (bp_target),
        .imem             (imem_bus),
        .pc_if            (pc_if),
        .npc_if           (npc_if),
        .predict_pc_if    (predict_pc_if),
        .inst_if          (inst_if),
        .valid_if         (valid_if),
        .except_happen_if (except_happen_if),
        .except_cause_if  (except_cause_if)
    );

    always #5 clk = ~clk;

    function automatic in_t mk_in(input logic s, input logic f, input logic [63:0] rp,
                                  input logic bt, input logic [63:0] tg, input logic a,
                                  input logic [31:0] rd, input logic flt);
        in_t v;
        v.stall = s; v.flush = f; v.redirect_pc = rp; v.bp_taken = bt;
        v.bp_target = tg; v.ack = a; v.rdata = rd; v.fault = flt;
        return v;
    endfunction

    function automatic ex_t mk_ex(input logic rq, input logic [63:0] ad, input logic vl,
                                  input logic [63:0] p, input logic [63:0] np,
                                  input logic [63:0] pr, input logic [31:0] in,
                                  input logic ex, input logic [3:0] ca);
        ex_t e;
        e.req = rq; e.addr = ad; e.valid = vl; e.pc = p; e.npc = np;
        e.pred = pr; e.inst = in; e.exc = ex; e.cause = ca;
        return e;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic apply(input in_t v);
        stall              = v.stall;
        flush              = v.flush;
        redirect_pc        = v.redirect_pc;
        bp_taken           = v.bp_taken;
        bp_target          = v.bp_target;
        imem_bus.imem_ack   = v.ack;
        imem_bus.imem_rdata = v.rdata;
        imem_bus.imem_fault = v.fault;
    endtask

    task automatic compare(input string tag, input ex_t e);
        chk({tag, " imem_req"},         imem_bus.imem_req,  e.req);
        chk({tag, " imem_addr"},        imem_bus.imem_addr, e.addr);
        chk({tag, " valid_if"},         valid_if,           e.valid);
        chk({tag, " pc_if"},            pc_if,              e.pc);
        chk({tag, " npc_if"},           npc_if,             e.npc);
        chk({tag, " predict_pc_if"},    predict_pc_if,      e.pred);
        chk({tag, " inst_if"},          inst_if,            e.inst);
        chk({tag, " except_happen_if"}, except_happen_if,   e.exc);
        chk({tag, " except_cause_if"},  except_cause_if,    e.cause);
    endtask

    initial begin
        // Inputs for the edge, then the outputs expected right after that edge.
        //                 stall flush redirect     bpt  target       ack  rdata          fault
        vin[0]  = mk_in(0, 0, 64'h0,   0, 64'h0,   0, 32'h0,        0);
        vex[0]  = mk_ex(1, 64'h0,   0, 64'h0,   64'h0,   64'h0,   32'h0,        0, 0);
        vin[1]  = mk_in(0, 0, 64'h0,   0, 64'h0,   0, 32'h0,        0);
        vex[1]  = mk_ex(1, 64'h0,   0, 64'h0,   64'h0,   64'h0,   32'h0,        0, 0);
        vin[2]  = mk_in(0, 0, 64'h0,   0, 64'h0,   1, 32'h00000013, 0);
        vex[2]  = mk_ex(0, 64'h0,   1, 64'h0,   64'h4,   64'h4,   32'h00000013, 0, 0);
        vin[3]  = mk_in(0, 0, 64'h0,   0, 64'h0,   0, 32'h0,        0);
        vex[3]  = mk_ex(1, 64'h4,   0, 64'h0,   64'h4,   64'h4,   32'h00000013, 0, 0);
        vin[4]  = mk_in(0, 0, 64'h0,   1, 64'h100, 1, 32'h00500093, 0);
        vex[4]  = mk_ex(0, 64'h4,   1, 64'h4,   64'h8,   64'h100, 32'h00500093, 0, 0);
        vin[5]  = mk_in(1, 0, 64'h0,   0, 64'h0,   0, 32'h0,        0);
        vex[5]  = mk_ex(0, 64'h4,   1, 64'h4,   64'h8,   64'h100, 32'h00500093, 0, 0);
        vin[6]  = mk_in(1, 0, 64'h0,   0, 64'h0,   0, 32'h0,        0);
        vex[6]  = mk_ex(0, 64'h4,   1, 64'h4,   64'h8,   64'h100, 32'h00500093, 0, 0);
        vin[7]  = mk_in(1, 0, 64'h0,   0, 64'h0,   0, 32'h0,        0);
        vex[7]  = mk_ex(0, 64'h4,   1, 64'h4,   64'h8,   64'h100, 32'h00500093, 0, 0);
        vin[8]  = mk_in(0, 0, 64'h0,   0, 64'h0,   0, 32'h0,        0);
        vex[8]  = mk_ex(1, 64'h100, 0, 64'h4,   64'h8,   64'h100, 32'h00500093, 0, 0);
        vin[9]  = mk_in(0, 1, 64'h200, 0, 64'h0,   0, 32'h0,        0);
        vex[9]  = mk_ex(1, 64'h100, 0, 64'h4,   64'h8,   64'h100, 32'h00500093, 0, 0);
        vin[10] = mk_in(0, 0, 64'h0,   0, 64'h0,   0, 32'h0,        0);
        vex[10] = mk_ex(1, 64'h100, 0, 64'h4,   64'h8,   64'h100, 32'h00500093, 0, 0);
        vin[11] = mk_in(0, 0, 64'h0,   0, 64'h0,   0, 32'h0,        0);
        vex[11] = mk_ex(1, 64'h100, 0, 64'h4,   64'h8,   64'h100, 32'h00500093, 0, 0);
        vin[12] = mk_in(0, 0, 64'h0,   0, 64'h0,   1, 32'hDEADBEEF, 0);
        vex[12] = mk_ex(1, 64'h200, 0, 64'h4,   64'h8,   64'h100, 32'h00500093, 0, 0);
        vin[13] = mk_in(0, 0, 64'h0,   0, 64'h0,   1, 32'h00000013, 0);
        vex[13] = mk_ex(0, 64'h200, 1, 64'h200, 64'h204, 64'h204, 32'h00000013, 0, 0);
        vin[14] = mk_in(1, 1, 64'h202, 0, 64'h0,   0, 32'h0,        0);
        vex[14] = mk_ex(0, 64'h202, 0, 64'h200, 64'h204, 64'h204, 32'h00000013, 0, 0);
        vin[15] = mk_in(0, 0, 64'h0,   0, 64'h0,   0, 32'h0,        0);
        vex[15] = mk_ex(0, 64'h202, 1, 64'h202, 64'h206, 64'h206, 32'h0,        1, 0);
        vin[16] = mk_in(0, 1, 64'h300, 0, 64'h0,   0, 32'h0,        0);
        vex[16] = mk_ex(1, 64'h300, 0, 64'h202, 64'h206, 64'h206, 32'h0,        1, 0);
        vin[17] = mk_in(0, 0, 64'h0,   0, 64'h0,   1, 32'hFFFFFFFF, 1);
        vex[17] = mk_ex(0, 64'h300, 1, 64'h300, 64'h304, 64'h304, 32'h0,        1, 1);
        vin[18] = mk_in(0, 0, 64'h0,   0, 64'h0,   0, 32'h0,        0);
        vex[18] = mk_ex(1, 64'h304, 0, 64'h300, 64'h304, 64'h304, 32'h0,        1, 1);
        vin[19] = mk_in(0, 1, 64'h400, 0, 64'h0,   1, 32'h00000013, 0);
        vex[19] = mk_ex(1, 64'h400, 0, 64'h300, 64'h304, 64'h304, 32'h0,        1, 1);
        vin[20] = mk_in(0, 1, 64'h500, 0, 64'h0,   0, 32'h0,        0);
        vex[20] = mk_ex(1, 64'h400, 0, 64'h300, 64'h304, 64'h304, 32'h0,        1, 1);
        vin[21] = mk_in(0, 1, 64'h600, 0, 64'h0,   0, 32'h0,        0);
        vex[21] = mk_ex(1, 64'h400, 0, 64'h300, 64'h304, 64'h304, 32'h0,        1, 1);
        vin[22] = mk_in(0, 0, 64'h0,   0, 64'h0,   1, 32'h00000013, 0);
        vex[22] = mk_ex(1, 64'h600, 0, 64'h300, 64'h304, 64'h304, 32'h0,        1, 1);
        vin[23] = mk_in(0, 0, 64'h0,   1, TOP,     1, 32'h00000013, 0);
        vex[23] = mk_ex(0, 64'h600, 1, 64'h600, 64'h604, TOP,     32'h00000013, 0, 0);
        vin[24] = mk_in(0, 0, 64'h0,   0, 64'h0,   0, 32'h0,        0);
        vex[24] = mk_ex(1, TOP,     0, 64'h600, 64'h604, TOP,     32'h00000013, 0, 0);
        vin[25] = mk_in(0, 0, 64'h0,   0, 64'h0,   1, 32'h00000073, 0);
        vex[25] = mk_ex(0, TOP,     1, TOP,     64'h0,   64'h0,   32'h00000073, 0, 0);

        apply(mk_in(0, 0, 64'h0, 0, 64'h0, 0, 32'h0, 0));

        // Reset state while rst is held.
        #12;
        compare("reset", mk_ex(0, 64'h0, 0, 64'h0, 64'h0, 64'h0, 32'h0, 0, 0));

        @(negedge clk);
        rst = 1'b0;
        apply(vin[0]);
        #1;
        chk("release no_req_before_edge", imem_bus.imem_req, 1'b0);
        #4;

        for (int i = 0; i < NV; i++) begin
            apply(vin[i]);
            @(posedge clk);
            #1;
            compare($sformatf("row%0d", i), vex[i]);
            @(negedge clk);
        end

        // Consume the last instruction: pc wraps to 0 and a request goes out.
        apply(mk_in(0, 0, 64'h0, 0, 64'h0, 0, 32'h0, 0));
        @(posedge clk);
        #1;
        chk("midrst pre imem_req", imem_bus.imem_req, 1'b1);
        chk("midrst pre imem_addr", imem_bus.imem_addr, 64'h0);

        // Asynchronous reset in the middle of the outstanding request.
        #2;
        rst = 1'b1;
        #1;
        chk("midrst async imem_req", imem_bus.imem_req, 1'b0);
        chk("midrst async valid_if", valid_if, 1'b0);
        chk("midrst async pc_if", pc_if, 64'h0);
        chk("midrst async predict_pc_if", predict_pc_if, 64'h0);
        chk("midrst async inst_if", inst_if, 32'h0);

        // A response arriving during reset is not registered.
        @(negedge clk);
        apply(mk_in(0, 0, 64'h0, 0, 64'h0, 1, 32'h00000055, 0));
        @(posedge clk);
        #1;
        chk("midrst ack valid_if", valid_if, 1'b0);
        chk("midrst ack inst_if", inst_if, 32'h0);
        chk("midrst ack imem_req", imem_bus.imem_req, 1'b0);

        // Release again: fresh request from the reset pc, then a normal fetch.
        @(negedge clk);
        rst = 1'b0;
        apply(mk_in(0, 0, 64'h0, 0, 64'h0, 0, 32'h0, 0));
        #1;
        chk("rerel no_req_before_edge", imem_bus.imem_req, 1'b0);
        @(posedge clk);
        #1;
        chk("rerel imem_req", imem_bus.imem_req, 1'b1);
        chk("rerel imem_addr", imem_bus.imem_addr, 64'h0);
        chk("rerel valid_if", valid_if, 1'b0);
        @(negedge clk);
        apply(mk_in(0, 0, 64'h0, 0, 64'h0, 1, 32'h00000013, 0));
        @(posedge clk);
        #1;
        compare("rerel fetch", mk_ex(0, 64'h0, 1, 64'h0, 64'h4, 64'h4, 32'h00000013, 0, 0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/inst_fetch_unit.md
INST_FETCH_UNIT -- requirements
Module: inst_fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 64'h0, is the first fetch address after reset.
REQ-002 clk  in  1  sole clock; all state updates on its rising edge.
REQ-003 rst  in  1  asynchronous, active-high reset.
REQ-004 stall  in  1  IF/ID stage hold; the held instruction is not consumed this cycle.
REQ-005 flush  in  1  redirect request from a later stage.
REQ-006 redirect_pc  in  64  fetch target used when flush=1.
REQ-007 bp_taken  in  1  branch-predictor taken hint for the current pc, sampled on the imem_ack cycle.
REQ-008 bp_target  in  64  predicted target, sampled with bp_taken.
REQ-009 imem_req  out  1  instruction-memory request.
REQ-010 imem_addr  out  64  request address, equal to the pc register.
REQ-011 imem_ack  in  1  response strobe; imem_rdata and imem_fault are valid only while this is 1.
REQ-012 imem_rdata  in  32  fetched instruction word.
REQ-013 imem_fault  in  1  instruction access fault.
REQ-014 pc_if, npc_if, predict_pc_if  out  64 each  fetched pc, pc+4, and predicted next pc.
REQ-015 inst_if  out  32  fetched instruction.
REQ-016 valid_if  out  1  the outputs hold an instruction or exception.
REQ-017 except_happen_if  out  1  fetch exception; except_cause_if (out, 4) carries mcause 0 (misaligned) or 1 (access fault).

Function
REQ-018 The FSM SHALL have three states: REQ (request outstanding), HOLD (output valid), DROP (discard stale response).
REQ-019 In REQ with pc[1:0]!=0, the unit SHALL keep imem_req=0 and enter HOLD next cycle with except_happen_if=1, except_cause_if=0, inst_if=0.
REQ-020 In REQ with pc aligned, the unit SHALL drive imem_req=1 and hold imem_addr stable until imem_ack.
REQ-021 On imem_ack in REQ with flush=0, the unit SHALL register pc_if=pc, npc_if=pc+4 (mod 2^64), inst_if=imem_rdata, except_happen_if=imem_fault, except_cause_if=1 if faulted, and predict_pc_if=bp_taken?bp_target:pc+4, then enter HOLD; valid_if=1 one cycle after ack.
REQ-022 A faulted fetch SHALL drive inst_if=0.
REQ-023 valid_if SHALL equal (state==HOLD).
REQ-024 In HOLD with flush=1, the unit SHALL load pc=redirect_pc and enter REQ; valid_if falls next cycle.
REQ-025 In HOLD with flush=0 and stall=0 (consumed), the unit SHALL load pc=predict_pc_if and enter REQ.
REQ-026 In HOLD with stall=1 and flush=0, all outputs and pc SHALL hold unchanged.
REQ-027 flush SHALL take priority over stall in every state.
REQ-028 On flush in REQ with imem_ack=1 in the same cycle, the response SHALL be discarded, pc loaded with redirect_pc, and the state stays REQ.
REQ-029 On flush in REQ with imem_ack=0, pc SHALL load redirect_pc, the state SHALL enter DROP, and imem_req/imem_addr SHALL keep the old request until ack.
REQ-030 The pc register SHALL update on flush before the state advances; imem_addr in DROP SHALL come from a separate latched request-address register.
REQ-031 In DROP, imem_ack SHALL be discarded and the state SHALL return to REQ with the new pc; a further flush in DROP SHALL only update pc.
REQ-032 The unit SHALL produce at most one instruction per two cycles; it SHALL NOT issue a new request while in HOLD.

Reset
REQ-033 While rst=1: pc=RESET_PC, state=REQ, imem_req=0, all *_if outputs 0, valid_if=0.
REQ-034 The first request SHALL be driven the cycle after rst deasserts.
REQ-035 Reset asserted mid-request SHALL abandon that request, and no response SHALL be registered.

Structure
REQ-036 The state encoding, RESET_PC default, and mcause constants (MISALIGNED=0, ACCESS_FAULT=1) SHALL live in the shared package.
REQ-037 Next-pc selection (redirect / predicted / hold) SHALL be a sub-module, fetch_pc_sel.

Verification
REQ-038 Reset release, 2-cycle ack latency, rdata=32'h00000013 -> imem_addr=0; then pc_if=0, npc_if=4, predict_pc_if=4, valid_if=1; next request addr=4.
REQ-039 Ack with bp_taken=1, bp_target=0x100 -> predict_pc_if=0x100; next imem_addr=0x100.
REQ-040 stall held 3 cycles in HOLD -> outputs unchanged, imem_req=0; release -> next request issued.
REQ-041 flush with redirect_pc=0x200 while a request waits 3 cycles for ack -> old addr held to ack, data dropped, valid_if stays 0, next imem_addr=0x200.
REQ-042 redirect_pc=0x202 -> no imem_req; valid_if=1, except_happen_if=1, except_cause_if=0, pc_if=0x202.
REQ-043 imem_fault=1 on ack -> except_happen_if=1, except_cause_if=1, inst_if=0.
